phase_sequencer: RTL

Parametrised multi-phase cycle generator. It produces a registered one-hot set of phase enables: phase[0] is cycle start, and for NUM_PHASES=3 the bits map to cycle, ram and internal. It adds halt-at-cycle-boundary, single-step and a completed-cycle counter. It sits at the top of the CPU datapath and drives every phase-qualified register and RAM access.

---
 rtl/phase_pkg.sv | 25 ++
 rtl/phase_sequencer_if.sv | 23 ++
 rtl/phase_ring.sv | 33 +++
 rtl/phase_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared types and helpers for the multi-phase machine-cycle sequencer.
package phase_pkg;

    localparam int MAX_PHASES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    // Ceiling log2, never below 1 so a 2-phase machine still gets a 1-bit index.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control and status bundle between the sequencer and the datapath it drives.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 16
);
    logic                  halt;
    logic                  step;
    logic [NUM_PHASES-1:0] phase;
    logic                  cycle_done;
    logic                  halted;
    logic                  stepping;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output halt, step,
        input  phase, cycle_done, halted, stepping, cycle_count
    );

    modport slave (
        input  halt, step,
        output phase, cycle_done, halted, stepping, cycle_count
    );
endinterface

// File: rtl/phase_ring.sv
// One-hot phase rotator: clear empties the ring, load0 seeds bit 0, adv rotates left.
module phase_ring #(
    parameter int NUM_PHASES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load0,
    input  logic                  clear,
    input  logic                  adv,
    output logic [NUM_PHASES-1:0] phase
);
    logic [NUM_PHASES-1:0] r_phase;
    logic [NUM_PHASES-1:0] w_rot;

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_rot
            localparam int PREV = (gi == 0) ? NUM_PHASES - 1 : gi - 1;
            assign w_rot[gi] = r_phase[PREV];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_phase <= '0;
        end else if (load0) begin
            r_phase <= NUM_PHASES'(1);
        end else if (adv) begin
            r_phase <= w_rot;
        end
    end

    assign phase = r_phase;
endmodule

// File: rtl/phase_sequencer.sv
// Machine-cycle generator with halt-at-boundary, single-step and a completed-cycle counter.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    phase_sequencer_if.slave  bus
);
    localparam int               IDX_W    = clog2(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic [CNT_W-1:0]      r_count;
    logic                  w_load0;
    logic                  w_clear;
    logic                  w_adv;
    logic                  w_at_last;
    logic [NUM_PHASES-1:0] w_phase;

    // The index mirrors the ring position so the boundary test is a plain compare.
    assign w_at_last = ((r_state == RUN) || (r_state == STEP)) && (r_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_load0      = 1'b0;
        w_clear      = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.halt) begin
                    w_state_next = HALTED;
                end else begin
                    w_state_next = RUN;
                    w_load0      = 1'b1;
                end
            end
            RUN: begin
                if (!w_at_last) begin
                    w_adv = 1'b1;
                end else if (bus.halt) begin
                    w_state_next = HALTED;
                    w_clear      = 1'b1;
                end else begin
                    w_load0 = 1'b1;
                end
            end
            HALTED: begin
                if (bus.step) begin
                    w_state_next = STEP;
                    w_load0      = 1'b1;
                end else if (!bus.halt) begin
                    w_state_next = RUN;
                    w_load0      = 1'b1;
                end
            end
            STEP: begin
                if (!w_at_last) begin
                    w_adv = 1'b1;
                end else begin
                    w_state_next = HALTED;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_clear      = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_idx_next = r_idx;
        if (w_load0 || w_clear) begin
            w_idx_next = '0;
        end else if (w_adv) begin
            w_idx_next = r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_at_last) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    phase_ring #(
        .NUM_PHASES (NUM_PHASES)
    ) u_ring (
        .clk   (clk),
        .reset (reset),
        .load0 (w_load0),
        .clear (w_clear),
        .adv   (w_adv),
        .phase (w_phase)
    );

    assign bus.phase       = w_phase;
    assign bus.cycle_done  = w_phase[NUM_PHASES-1];
    assign bus.halted      = (r_state == HALTED);
    assign bus.stepping    = (r_state == STEP);
    assign bus.cycle_count = r_count;

    // Phase must be one-hot while cycling, zero otherwise, and agree with the index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (NUM_PHASES >= 2 && NUM_PHASES <= MAX_PHASES);
            assert ($onehot0(w_phase));
            assert ((w_phase == '0) == ((r_state == IDLE) || (r_state == HALTED)));
            assert ((w_phase == '0) || (w_phase == (NUM_PHASES'(1) << r_idx)));
        end
    end
endmodule
